// File: rtl/ex_mc_stall_ctrl_pkg.sv
// rtl/ex_mc_stall_ctrl_pkg.sv - shared constants for the EX multi-cycle stall controller
package ex_mc_stall_ctrl_pkg;

    typedef logic [5:0] stall_vec_t;

    // Per-stage stall levels
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Stall masks: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb
    localparam stall_vec_t STALL_NONE = 6'b000000;
    localparam stall_vec_t STALL_ID   = 6'b000111;
    localparam stall_vec_t STALL_EX   = 6'b001111;
    localparam stall_vec_t STALL_MEM  = 6'b011111;

    // Sequencer state codes
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MADD2    = 2'd1;
    localparam logic [1:0] ST_DIV_BUSY = 2'd2;

endpackage

// File: rtl/ex_mc_stall_ctrl.sv
// rtl/ex_mc_stall_ctrl.sv - multi-cycle EX op sequencer and pipeline stall vector
module ex_mc_stall_ctrl
    import ex_mc_stall_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = 40,
    parameter int WDOG_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stallreq_id_i,
    input  logic       stallreq_mem_i,
    input  logic       ex_madd_i,
    input  logic       ex_div_i,
    input  logic       ex_div_signed_i,
    input  logic       div_ready_i,
    output logic [5:0] stall_o,
    output logic [1:0] cnt_o,
    output logic       div_start_o,
    output logic       div_signed_o,
    output logic       div_annul_o,
    output logic       div_timeout_o
);

    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(DIV_TIMEOUT - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = {WDOG_W{1'b1}};

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WDOG_W-1:0] wdog;
    logic              stallreq_ex;
    logic              div_launch;
    logic              timeout_hit;

    // Deepest requesting stage wins: mem freezes through mem, ex through ex, id through id
    function automatic stall_vec_t stall_vec(input logic req_mem, input logic req_ex,
                                             input logic req_id);
        if (req_mem)
            return STALL_MEM;
        else if (req_ex)
            return STALL_EX;
        else if (req_id)
            return STALL_ID;
        else
            return STALL_NONE;
    endfunction

    // Mealy decode of the sequencer: stall request, madd phase, divider handshake, next state
    always_comb begin
        state_nxt   = state;
        stallreq_ex = NO_STOP;
        cnt_o       = 2'd0;
        div_start_o = 1'b0;
        div_annul_o = 1'b0;
        div_launch  = 1'b0;
        timeout_hit = 1'b0;
        if (rst) begin
            div_annul_o = 1'b1;
            state_nxt   = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A frozen EX must not launch anything; madd wins an illegal madd+div
                    if (!stallreq_mem_i) begin
                        if (ex_madd_i) begin
                            stallreq_ex = STOP;
                            state_nxt   = ST_MADD2;
                        end else if (ex_div_i) begin
                            stallreq_ex = STOP;
                            div_start_o = 1'b1;
                            div_launch  = 1'b1;
                            state_nxt   = ST_DIV_BUSY;
                        end
                    end
                end
                ST_MADD2: begin
                    cnt_o = 2'd1;
                    if (!stallreq_mem_i)
                        state_nxt = ST_IDLE;
                end
                ST_DIV_BUSY: begin
                    if (!div_ready_i && wdog == WDOG_LAST) begin
                        // Give up on the divider; EX retires with stale hi/lo
                        div_annul_o = 1'b1;
                        timeout_hit = 1'b1;
                        state_nxt   = ST_IDLE;
                    end else if (!div_ready_i) begin
                        stallreq_ex = STOP;
                        div_start_o = 1'b1;
                    end else if (!stallreq_mem_i) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        // Result ready but mem is stalled: keep start so the divider holds it
                        div_start_o = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign stall_o = rst ? STALL_NONE : stall_vec(stallreq_mem_i, stallreq_ex, stallreq_id_i);

    // State, divide watchdog, captured sign and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            wdog          <= '0;
            div_signed_o  <= 1'b0;
            div_timeout_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (div_launch) begin
                wdog         <= '0;
                div_signed_o <= ex_div_signed_i;
            end else if (state == ST_DIV_BUSY && wdog != WDOG_MAX) begin
                wdog <= wdog + 1'b1;
            end
            if (timeout_hit)
                div_timeout_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_mc_stall_ctrl.sv
// tb/tb_ex_mc_stall_ctrl.sv - scoreboard bench for ex_mc_stall_ctrl
module tb_ex_mc_stall_ctrl;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_ID   = 6'b000111;
    localparam logic [5:0] S_EX   = 6'b001111;
    localparam logic [5:0] S_MEM  = 6'b011111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stallreq_id_i = 1'b0;
    logic       stallreq_mem_i = 1'b0;
    logic       ex_madd_i = 1'b0;
    logic       ex_div_i = 1'b0;
    logic       ex_div_signed_i = 1'b0;
    logic       div_ready_i = 1'b0;
    logic [5:0] stall_o;
    logic [1:0] cnt_o;
    logic       div_start_o;
    logic       div_signed_o;
    logic       div_annul_o;
    logic       div_timeout_o;

    logic [11:0] exp_q[$];
    int          total = 0;
    int          bad = 0;

    ex_mc_stall_ctrl #(.DIV_TIMEOUT(40), .WDOG_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id_i  (stallreq_id_i),
        .stallreq_mem_i (stallreq_mem_i),
        .ex_madd_i      (ex_madd_i),
        .ex_div_i       (ex_div_i),
        .ex_div_signed_i(ex_div_signed_i),
        .div_ready_i    (div_ready_i),
        .stall_o        (stall_o),
        .cnt_o          (cnt_o),
        .div_start_o    (div_start_o),
        .div_signed_o   (div_signed_o),
        .div_annul_o    (div_annul_o),
        .div_timeout_o  (div_timeout_o)
    );

    always #5 clk = ~clk;

    wire [11:0] outv = {stall_o, cnt_o, div_start_o, div_signed_o, div_annul_o, div_timeout_o};

    function automatic logic [11:0] pk(input logic [5:0] s, input logic [1:0] c, input logic st,
                                       input logic sg, input logic an, input logic to);
        return {s, c, st, sg, an, to};
    endfunction

    // Packed stimulus: {rst, id, mem, madd, div, signed, ready}
    task automatic drive(input logic [6:0] v);
        {rst, stallreq_id_i, stallreq_mem_i, ex_madd_i, ex_div_i, ex_div_signed_i, div_ready_i} = v;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            drive(7'b1000101);
            exp_q.push_back(pk(S_NONE, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outv !== e) begin
                bad++;
                $display("FAIL reset c%0d got=%h exp=%h", c, outv, e);
            end
        end
    endtask

    task automatic test_madd();
        logic [6:0]  st [3];
        logic [11:0] ex [3];
        logic [11:0] e;
        st = '{7'b0001000, 7'b0001000, 7'b0000000};
        ex = '{pk(S_EX, 2'd0, 0, 0, 0, 0), pk(S_NONE, 2'd1, 0, 0, 0, 0), pk(S_NONE, 2'd0, 0, 0, 0, 0)};
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            drive(st[c]);
            exp_q.push_back(ex[c]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outv !== e) begin
                bad++;
                $display("FAIL madd c%0d got=%h exp=%h", c, outv, e);
            end
        end
    endtask

    task automatic test_madd_mem();
        logic [6:0]  st [6];
        logic [11:0] ex [6];
        logic [11:0] e;
        st = '{7'b0001000, 7'b0011000, 7'b0011000, 7'b0011000, 7'b0001000, 7'b0000000};
        ex = '{pk(S_EX, 2'd0, 0, 0, 0, 0), pk(S_MEM, 2'd1, 0, 0, 0, 0), pk(S_MEM, 2'd1, 0, 0, 0, 0),
               pk(S_MEM, 2'd1, 0, 0, 0, 0), pk(S_NONE, 2'd1, 0, 0, 0, 0), pk(S_NONE, 2'd0, 0, 0, 0, 0)};
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            drive(st[c]);
            exp_q.push_back(ex[c]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outv !== e) begin
                bad++;
                $display("FAIL madd_mem c%0d got=%h exp=%h", c, outv, e);
            end
        end
    endtask

    task automatic test_mem_idle();
        logic [6:0]  st [6];
        logic [11:0] ex [6];
        logic [11:0] e;
        st = '{7'b0011000, 7'b0000000, 7'b0001110, 7'b0001000, 7'b0000000, 7'b0100000};
        ex = '{pk(S_MEM, 2'd0, 0, 0, 0, 0), pk(S_NONE, 2'd0, 0, 0, 0, 0), pk(S_EX, 2'd0, 0, 0, 0, 0),
               pk(S_NONE, 2'd1, 0, 0, 0, 0), pk(S_NONE, 2'd0, 0, 0, 0, 0), pk(S_ID, 2'd0, 0, 0, 0, 0)};
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            drive(st[c]);
            exp_q.push_back(ex[c]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outv !== e) begin
                bad++;
                $display("FAIL mem_idle c%0d got=%h exp=%h", c, outv, e);
            end
        end
    endtask

    task automatic test_div();
        logic [11:0] e;
        for (int c = 0; c < 36; c++) begin
            @(posedge clk); #1;
            drive({4'b0000, c < 35, 1'b1, c == 34});
            if (c == 0)
                exp_q.push_back(pk(S_EX, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
            else if (c < 34)
                exp_q.push_back(pk(S_EX, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
            else
                exp_q.push_back(pk(S_NONE, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outv !== e) begin
                bad++;
                $display("FAIL div c%0d got=%h exp=%h", c, outv, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0]  st [7];
        logic [11:0] ex [7];
        logic [11:0] e;
        st = '{7'b0000100, 7'b0000101, 7'b0100100, 7'b0100100, 7'b0100101, 7'b0100000, 7'b0000000};
        ex = '{pk(S_EX, 2'd0, 1, 1, 0, 0), pk(S_NONE, 2'd0, 0, 0, 0, 0), pk(S_EX, 2'd0, 1, 0, 0, 0),
               pk(S_EX, 2'd0, 1, 0, 0, 0), pk(S_ID, 2'd0, 0, 0, 0, 0), pk(S_ID, 2'd0, 0, 0, 0, 0),
               pk(S_NONE, 2'd0, 0, 0, 0, 0)};
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            drive(st[c]);
            exp_q.push_back(ex[c]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outv !== e) begin
                bad++;
                $display("FAIL back_to_back c%0d got=%h exp=%h", c, outv, e);
            end
        end
    endtask

    task automatic test_div_mem();
        logic [6:0]  st [5];
        logic [11:0] ex [5];
        logic [11:0] e;
        st = '{7'b0000110, 7'b0010111, 7'b0010111, 7'b0000111, 7'b0000000};
        ex = '{pk(S_EX, 2'd0, 1, 0, 0, 0), pk(S_MEM, 2'd0, 1, 1, 0, 0), pk(S_MEM, 2'd0, 1, 1, 0, 0),
               pk(S_NONE, 2'd0, 0, 1, 0, 0), pk(S_NONE, 2'd0, 0, 1, 0, 0)};
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            drive(st[c]);
            exp_q.push_back(ex[c]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outv !== e) begin
                bad++;
                $display("FAIL div_mem c%0d got=%h exp=%h", c, outv, e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [11:0] e;
        for (int c = 0; c < 43; c++) begin
            @(posedge clk); #1;
            drive({4'b0000, c <= 40, 1'b0, 1'b0});
            if (c == 0)
                exp_q.push_back(pk(S_EX, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
            else if (c < 40)
                exp_q.push_back(pk(S_EX, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
            else if (c == 40)
                exp_q.push_back(pk(S_NONE, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
            else
                exp_q.push_back(pk(S_NONE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outv !== e) begin
                bad++;
                $display("FAIL timeout c%0d got=%h exp=%h", c, outv, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0]  st [4];
        logic [11:0] ex [4];
        logic [11:0] e;
        st = '{7'b0000110, 7'b0000110, 7'b1000110, 7'b0000000};
        ex = '{pk(S_EX, 2'd0, 1, 0, 0, 1), pk(S_EX, 2'd0, 1, 1, 0, 1), pk(S_NONE, 2'd0, 0, 1, 1, 1),
               pk(S_NONE, 2'd0, 0, 0, 0, 0)};
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            drive(st[c]);
            exp_q.push_back(ex[c]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outv !== e) begin
                bad++;
                $display("FAIL reset_mid c%0d got=%h exp=%h", c, outv, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_madd();
        test_madd_mem();
        test_mem_idle();
        test_div();
        test_back_to_back();
        test_div_mem();
        test_timeout();
        test_reset_mid();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
